// File: rtl/div_iter_32b.sv
// div_iter_32b: restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero, overflow and |divisor|>|dividend| in one cycle.
module div_iter_32b #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, nxt;
  logic [XLEN-1:0] quo, dvs, rem, dvd, ma, mb, qf, rf;
  logic [XLEN:0] sh, t;
  logic [CW-1:0] cnt;
  logic is_rem, sd, sv, dz, ovf, sgn, sd_in, sv_in, dz_in, ovf_in, early;
  assign sgn    = ~op[0];
  assign sd_in  = sgn & dividend[XLEN-1];
  assign sv_in  = sgn & divisor[XLEN-1];
  assign ma     = sd_in ? -dividend : dividend;
  assign mb     = sv_in ? -divisor : divisor;
  assign dz_in  = divisor == '0;
  assign ovf_in = sgn & (dividend == MIN) & (&divisor);
`ifdef DIV_EARLY_OUT_EN
  assign early  = dz_in | ovf_in | (mb > ma);
`else
  assign early  = 1'b0;
`endif
  assign busy   = state != IDLE;
  assign valid  = state == DONE;
  assign sh     = {rem, quo[XLEN-1]};
  assign t      = sh - {1'b0, dvs};
  assign qf     = dz ? '1 : ovf ? MIN : (sd ^ sv) ? -quo : quo;
  assign rf     = dz ? dvd : ovf ? '0 : sd ? -rem : rem;
  always_comb begin
    nxt = state;
    if (flush) nxt = IDLE;
    else begin
      case (state)
        IDLE:    nxt = start ? (early ? DONE : CALC) : IDLE;
        CALC:    nxt = (cnt == CW'(XLEN-1)) ? FIX : CALC;
        FIX:     nxt = DONE;
        default: nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {quo, dvs, rem, dvd, result} <= '0;
      cnt <= '0;
      {is_rem, sd, sv, dz, ovf} <= '0;
    end else if (!flush) begin
      if (state == IDLE && start) begin
        is_rem <= op[1];
        quo    <= ma;
        dvs    <= mb;
        rem    <= '0;
        cnt    <= '0;
        sd     <= sd_in;
        sv     <= sv_in;
        dz     <= dz_in;
        ovf    <= ovf_in;
        dvd    <= dividend;
`ifdef DIV_EARLY_OUT_EN
        if (early) result <= op[1] ? (ovf_in ? '0 : dividend) : (dz_in ? '1 : ovf_in ? MIN : '0);
`endif
      end
      // negative trial (borrow in the top bit) keeps the shifted remainder
      if (state == CALC) begin
        rem <= t[XLEN] ? sh[XLEN-1:0] : t[XLEN-1:0];
        quo <= {quo[XLEN-2:0], ~t[XLEN]};
        cnt <= cnt + CW'(1);
      end
      if (state == FIX) result <= is_rem ? rf : qf;
    end
  end
endmodule
